layer_2_5_mac_sequencer: RTL
============================

Name: layer_2_5_mac_sequencer

Overview:
- Control front-end for the 5-lane layer_2_5_multiply MAC.
- Accepts a valid/ready stream of terms (5 vector operands plus a shared multiplier) grouped by in_last.
- Drives the MAC's load/accumulate pins per term, waits a fixed MAC pipeline latency after the last term, captures the five sums and presents them with a valid/ready handshake to the next layer stage.

Parameters:
- VECTOR_SIZE, 8, width of each vector operand
- MULTIPLIER_SIZE, 8, width of shared multiplier operand
- MAX_TERMS, 16, maximum terms per group; must be >= 2
- MAC_LATENCY, 1, cycles from mac_load high until the MAC sums reflect that term; range 1..7
- Derived: ACC_W = VECTOR_SIZE+MULTIPLIER_SIZE+1; CNT_W = $clog2(MAX_TERMS+1)

Ports:
- clk  input  1  clock, rising edge
- reset  input  1  synchronous, active-high
- in_valid  input  1  term available
- in_ready  output  1  sequencer accepts term
- in_last  input  1  term is last of group
- in_vector_1..in_vector_5  input  VECTOR_SIZE each  lane operands
- in_multiplier  input  MULTIPLIER_SIZE  shared multiplier
- mac_vector_1..mac_vector_5  output  VECTOR_SIZE each  registered operands to MAC
- mac_multiplier  output  MULTIPLIER_SIZE  registered multiplier to MAC
- mac_load  output  1  MAC load strobe
- mac_accumulate  output  1  0 = first term (overwrite), 1 = add to sum
- mac_acc_1..mac_acc_5  input  ACC_W each  MAC sums
- out_valid  output  1  result group available
- out_ready  input  1  downstream accepts
- out_acc_1..out_acc_5  output  ACC_W each  captured sums
- out_terms  output  CNT_W  terms in captured group
- busy  output  1  high in any state other than IDLE
- err_overflow  output  1  sticky group-overflow flag

Behaviour:
- Reset: all outputs 0, state IDLE, counters 0. Reset mid-group discards the group with no output. The MAC shares the same reset.
- States:
  - IDLE: in_ready=1. On accept, load regs, mac_accumulate=0, term_cnt=1. Go to FEED, or to DRAIN if in_last.
  - FEED: in_ready=1. On accept, mac_accumulate=1, term_cnt+1. Go to DRAIN if in_last or overflow.
  - DRAIN: in_ready=0. lat_cnt counts from 0. When lat_cnt==MAC_LATENCY, capture mac_acc_1..5 and term_cnt into out regs, then go to HOLD.
  - HOLD: out_valid=1, in_ready=0, out regs stable. On out_ready, go to IDLE; out_valid drops next cycle.
- mac_* outputs are registered. mac_load is high exactly one cycle after each accepted term, otherwise 0. mac_vector/mac_multiplier hold the last value when mac_load=0.
- No accept cycle in FEED (in_valid=0): mac_load=0, MAC sum untouched, state held.
- Latency: if the last term is accepted in cycle T, out_valid asserts in cycle T+2+MAC_LATENCY.
- Throughput: one term per cycle in IDLE/FEED. Minimum gap between groups = drain + handshake; no overlap with HOLD.
- Overflow: if a non-last term is accepted when term_cnt==MAX_TERMS-1, that term is treated as last and err_overflow is set (sticky until reset). Following terms start a new group.
- in_ready is combinational from state only, never from in_valid. in_valid and in_ready high with reset high: no accept.

Optional Feature:
- Macro LAYER_2_5_SEQ_PERF_EN.
- Defined: adds outputs perf_groups (16-bit, groups delivered), perf_stall (16-bit, cycles in HOLD with out_ready=0) and input perf_clear (synchronous clear, reset has priority). Counters saturate at 16'hFFFF.
- Undefined: these ports and their logic do not exist; all other behaviour is identical.

Test Plan:
- 3-term group, lane1 (7,4,6) × mult (2,2,3), other lanes 7 × (2,2,3), MAC_LATENCY=1 with layer_2_5_multiply attached -> mac_accumulate pattern 0,1,1; out_acc_1=40, out_acc_2..5=49, out_terms=3; out_valid exactly 3 cycles after last accept.
- Single term 200 × 15 with in_last=1 -> direct IDLE→DRAIN; out_acc_1=3000, out_terms=1, mac_accumulate=0.
- Hold out_ready=0 for 5 cycles -> out_valid and out_acc stable, in_ready=0 throughout; accept on cycle 6, IDLE next cycle. With PERF_EN: perf_stall=5, perf_groups=1.
- in_valid gaps: 4 terms of 1×1 with idle cycles between -> mac_load only on accepted terms; out_acc_1=4.
- Overflow, MAX_TERMS=4: 6 terms of 1×1, in_last only on the 6th -> first result out_terms=4 (sum 4), err_overflow=1; second result out_terms=2 (sum 2).
- Reset asserted mid-FEED after 2 terms -> next cycle busy=0, out_valid=0, mac_load=0, err_overflow=0; fresh 1-term group (3×3) gives out_acc_1=9.

Source files
------------

// File: rtl/layer_2_5_mac_sequencer.sv
// layer_2_5_mac_sequencer: control front-end for the 5-lane layer_2_5_multiply MAC.
// Collects a group of terms from a valid/ready stream, strobes them into the MAC,
// waits out the MAC pipeline latency and hands the five captured sums downstream.
// Optional build macro LAYER_2_5_SEQ_PERF_EN adds perf_groups / perf_stall counters
// and the perf_clear input; without it those ports do not exist.
//
// Handshake: a transfer happens on a rising edge where valid and ready are both high
// (and reset is low); ready depends only on the FSM state, never on valid, and the
// output side keeps out_valid and out_acc/out_terms stable until out_ready is seen.
module layer_2_5_mac_sequencer #(
  parameter int VECTOR_SIZE     = 8,
  parameter int MULTIPLIER_SIZE = 8,
  parameter int MAX_TERMS       = 16,
  parameter int MAC_LATENCY     = 1,
  parameter int ACC_W           = VECTOR_SIZE + MULTIPLIER_SIZE + 1,
  parameter int CNT_W           = $clog2(MAX_TERMS + 1)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       in_last,
  input  logic [VECTOR_SIZE-1:0]     in_vector_1,
  input  logic [VECTOR_SIZE-1:0]     in_vector_2,
  input  logic [VECTOR_SIZE-1:0]     in_vector_3,
  input  logic [VECTOR_SIZE-1:0]     in_vector_4,
  input  logic [VECTOR_SIZE-1:0]     in_vector_5,
  input  logic [MULTIPLIER_SIZE-1:0] in_multiplier,
  output logic [VECTOR_SIZE-1:0]     mac_vector_1,
  output logic [VECTOR_SIZE-1:0]     mac_vector_2,
  output logic [VECTOR_SIZE-1:0]     mac_vector_3,
  output logic [VECTOR_SIZE-1:0]     mac_vector_4,
  output logic [VECTOR_SIZE-1:0]     mac_vector_5,
  output logic [MULTIPLIER_SIZE-1:0] mac_multiplier,
  output logic                       mac_load,
  output logic                       mac_accumulate,
  input  logic [ACC_W-1:0]           mac_acc_1,
  input  logic [ACC_W-1:0]           mac_acc_2,
  input  logic [ACC_W-1:0]           mac_acc_3,
  input  logic [ACC_W-1:0]           mac_acc_4,
  input  logic [ACC_W-1:0]           mac_acc_5,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [ACC_W-1:0]           out_acc_1,
  output logic [ACC_W-1:0]           out_acc_2,
  output logic [ACC_W-1:0]           out_acc_3,
  output logic [ACC_W-1:0]           out_acc_4,
  output logic [ACC_W-1:0]           out_acc_5,
  output logic [CNT_W-1:0]           out_terms,
  output logic                       busy,
  output logic                       err_overflow
`ifdef LAYER_2_5_SEQ_PERF_EN
  ,
  input  logic                       perf_clear,
  output logic [15:0]                perf_groups,
  output logic [15:0]                perf_stall
`endif
);

  // Latency counter only needs to reach MAC_LATENCY (at most 7).
  localparam int LAT_W = 3;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FEED  = 2'd1,
    S_DRAIN = 2'd2,
    S_HOLD  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   term_cnt_q;
  logic [LAT_W-1:0]   lat_cnt_q;
  logic               accept;
  logic               at_limit;
  logic               ovf_hit;
  logic               drain_done;

  assign accept     = in_valid & in_ready & ~reset;
  // One more non-last term in FEED would reach MAX_TERMS: close the group there.
  assign at_limit   = (state_q == S_FEED) && (term_cnt_q == CNT_W'(MAX_TERMS - 1));
  assign ovf_hit    = accept & at_limit & ~in_last;
  assign drain_done = (state_q == S_DRAIN) && (lat_cnt_q == LAT_W'(MAC_LATENCY));

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic: group collection, MAC drain, result hold.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = in_last ? S_DRAIN : S_FEED;
      S_FEED:  if (accept && (in_last || at_limit)) state_d = S_DRAIN;
      S_DRAIN: if (drain_done) state_d = S_HOLD;
      S_HOLD:  if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State-decoded outputs.
  always_comb begin
    in_ready  = (state_q == S_IDLE) || (state_q == S_FEED);
    out_valid = (state_q == S_HOLD);
    busy      = (state_q != S_IDLE);
  end

  // MAC drive registers, term/latency counters, result capture and overflow flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      mac_vector_1   <= '0;
      mac_vector_2   <= '0;
      mac_vector_3   <= '0;
      mac_vector_4   <= '0;
      mac_vector_5   <= '0;
      mac_multiplier <= '0;
      mac_load       <= 1'b0;
      mac_accumulate <= 1'b0;
      term_cnt_q     <= '0;
      lat_cnt_q      <= '0;
      out_acc_1      <= '0;
      out_acc_2      <= '0;
      out_acc_3      <= '0;
      out_acc_4      <= '0;
      out_acc_5      <= '0;
      out_terms      <= '0;
      err_overflow   <= 1'b0;
    end else begin
      mac_load <= accept;
      if (accept) begin
        mac_vector_1   <= in_vector_1;
        mac_vector_2   <= in_vector_2;
        mac_vector_3   <= in_vector_3;
        mac_vector_4   <= in_vector_4;
        mac_vector_5   <= in_vector_5;
        mac_multiplier <= in_multiplier;
        // First term of a group overwrites the MAC sum, later ones add.
        mac_accumulate <= (state_q == S_FEED);
        term_cnt_q     <= (state_q == S_IDLE) ? CNT_W'(1) : term_cnt_q + CNT_W'(1);
      end
      if (state_q == S_DRAIN) lat_cnt_q <= lat_cnt_q + LAT_W'(1);
      else                    lat_cnt_q <= '0;
      if (drain_done) begin
        out_acc_1 <= mac_acc_1;
        out_acc_2 <= mac_acc_2;
        out_acc_3 <= mac_acc_3;
        out_acc_4 <= mac_acc_4;
        out_acc_5 <= mac_acc_5;
        out_terms <= term_cnt_q;
      end
      if (ovf_hit) err_overflow <= 1'b1;
    end
  end

`ifdef LAYER_2_5_SEQ_PERF_EN
  // Saturating counters of delivered groups and back-pressured HOLD cycles.
  always_ff @(posedge clk) begin
    if (reset || perf_clear) begin
      perf_groups <= '0;
      perf_stall  <= '0;
    end else if (state_q == S_HOLD) begin
      if (out_ready && perf_groups != 16'hFFFF) perf_groups <= perf_groups + 16'd1;
      if (!out_ready && perf_stall != 16'hFFFF) perf_stall <= perf_stall + 16'd1;
    end
  end
`endif

endmodule
